mem_port_arbiter: RTL and testbench

Two-requester arbiter sharing the single-port unified memory between the multi-cycle core (port 0) and the program loader/DMA engine (port 1). Each cycle it picks at most one requester, drives the memory address/write port from that requester, and returns synchronous read data one cycle later to the requester that issued the read. It sits between the core's memory interface, the loader, and the memory macro. Port 1 may lock the memory for bounded bursts.

---
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the single-port unified memory.
// Port 0 is the multi-cycle core and port 1 is the loader/DMA engine.
// At most one access is issued per cycle, and read data returns one cycle
// later to the port that issued the read. Port 1 may claim priority with
// lock1 for up to MAX_BURST consecutive contended beats. After that, the
// round-robin pointer hands the next tie to port 0.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  logic             last_winner_q, last_winner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             rd_tag0_q, rd_tag0_d;
  logic             rd_tag1_q, rd_tag1_d;
  logic             lock_win;

  // A locked port-1 beat wins a tie only while its burst budget lasts.
  assign lock_win = lock1 && (burst_cnt_q < BURST_MAX);

  // Grant selection. Grants are suppressed while reset is high.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        if (lock_win)           gnt1 = 1'b1;
        else if (last_winner_q) gnt0 = 1'b1;
        else                    gnt1 = 1'b1;
      end else if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Steer the granted port onto the memory. The bus is idle-zero otherwise.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_addr  = addr0;
      mem_we    = we0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_addr  = addr1;
      mem_we    = we1;
      mem_wdata = wdata1;
    end
  end

  // Next state: round-robin pointer, burst budget and pending-read tags.
  always_comb begin
    last_winner_d = last_winner_q;
    burst_cnt_d   = burst_cnt_q;
    rd_tag0_d     = gnt0 & ~we0;
    rd_tag1_d     = gnt1 & ~we1;
    if (gnt0) begin
      last_winner_d = 1'b0;
      burst_cnt_d   = '0;
    end else if (gnt1) begin
      last_winner_d = 1'b1;
      if (!lock1)                       burst_cnt_d = '0;
      else if (burst_cnt_q < BURST_MAX) burst_cnt_d = burst_cnt_q + 1'b1;
    end
  end

  // State register. Reset drops any pending read and rearms port 0 for the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner_q <= 1'b1;
      burst_cnt_q   <= '0;
      rd_tag0_q     <= 1'b0;
      rd_tag1_q     <= 1'b0;
    end else begin
      last_winner_q <= last_winner_d;
      burst_cnt_q   <= burst_cnt_d;
      rd_tag0_q     <= rd_tag0_d;
      rd_tag1_q     <= rd_tag1_d;
    end
  end

  // Read return goes to the port that issued last cycle's read.
  // It is masked during reset so a dropped read never shows up.
  assign rvalid0 = rd_tag0_q & ~reset;
  assign rvalid1 = rd_tag1_q & ~reset;
  assign rdata0  = rvalid0 ? mem_rdata : '0;
  assign rdata1  = rvalid1 ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter.
// It provides a synchronous memory, a behavioural reference model and directed stimulus.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [DW-1:0] rdata0, rdata1, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] mem    [0:255];
  logic [DW-1:0] shadow [0:255];

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Preload the memory and the model's view of it.
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 32'h5A000000 + i;
      shadow[i] = 32'h5A000000 + i;
    end
    mem[0] = 32'h11111111;         shadow[0] = 32'h11111111;
    mem[1] = 32'h22222222;         shadow[1] = 32'h22222222;
    mem[8'h10 >> 2] = 32'hDEADBEEF; shadow[8'h10 >> 2] = 32'hDEADBEEF;
  end

  // Memory macro: registered read, write commits on the edge.
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr[9:2]];
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  // Reference model. It predicts this cycle's outputs from the arbitration
  // rules, then advances its own view of the state.
  int          m_lw = 1;
  int          m_bc = 0;
  bit          m_p0 = 0, m_p1 = 0;
  logic [31:0] m_d0 = '0, m_d1 = '0;
  bit          e0, e1, ewe;
  logic [31:0] ea, ew;

  always @(negedge clk) begin
    e0 = 0;
    e1 = 0;
    if (!reset) begin
      if (req0 && req1) begin
        if (lock1 && m_bc < MB) e1 = 1;
        else if (m_lw == 1)     e0 = 1;
        else                    e1 = 1;
      end else if (req0) e0 = 1;
      else if (req1)     e1 = 1;
    end
    ea  = e0 ? addr0 : (e1 ? addr1 : 32'h0);
    ew  = e0 ? wdata0 : (e1 ? wdata1 : 32'h0);
    ewe = e0 ? we0 : (e1 ? we1 : 1'b0);
    check("m_gnt0", gnt0, e0);
    check("m_gnt1", gnt1, e1);
    check("m_addr", mem_addr, ea);
    check("m_we", mem_we, ewe);
    check("m_wdata", mem_wdata, ew);
    check("m_rvalid0", rvalid0, m_p0 && !reset);
    check("m_rvalid1", rvalid1, m_p1 && !reset);
    check("m_rdata0", rdata0, (m_p0 && !reset) ? m_d0 : 32'h0);
    check("m_rdata1", rdata1, (m_p1 && !reset) ? m_d1 : 32'h0);
    if (reset) begin
      m_lw = 1; m_bc = 0; m_p0 = 0; m_p1 = 0;
    end else begin
      m_p0 = e0 && !we0;
      m_p1 = e1 && !we1;
      if (e0) begin
        m_d0 = shadow[addr0[9:2]];
        if (we0) shadow[addr0[9:2]] = wdata0;
        m_lw = 0;
        m_bc = 0;
      end
      if (e1) begin
        m_d1 = shadow[addr1[9:2]];
        if (we1) shadow[addr1[9:2]] = wdata1;
        m_lw = 1;
        m_bc = lock1 ? ((m_bc + 1 > MB) ? MB : m_bc + 1) : 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  bit g0, g1;

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single read from port 0.
    req0 = 1; we0 = 0; addr0 = 32'h10;
    @(negedge clk);
    check("rd_gnt0", gnt0, 1);
    check("rd_gnt1", gnt1, 0);
    check("rd_addr", mem_addr, 32'h10);
    check("rd_we", mem_we, 0);
    @(posedge clk); #1 req0 = 0;
    @(negedge clk);
    check("rd_rvalid0", rvalid0, 1);
    check("rd_rdata0", rdata0, 32'hDEADBEEF);
    check("rd_rvalid1", rvalid1, 0);
    check("rd_rdata1", rdata1, 0);

    // Unlocked port-1 write with port 0 idle.
    @(posedge clk); #1 req1 = 1; we1 = 1; addr1 = 32'h30; wdata1 = 32'hCAFE0001; lock1 = 0;
    @(negedge clk);
    check("w1_gnt1", gnt1, 1);
    check("w1_gnt0", gnt0, 0);
    check("w1_we", mem_we, 1);
    check("w1_wdata", mem_wdata, 32'hCAFE0001);
    @(posedge clk); #1 req1 = 0;
    @(negedge clk);
    check("w1_burst", dut.burst_cnt_q, 0);
    check("w1_mem", mem[32'h30 >> 2], 32'hCAFE0001);

    // Contended writes without lock: round-robin.
    @(posedge clk); #1
    req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'hA0000000;
    req1 = 1; we1 = 1; addr1 = 32'h24; wdata1 = 32'hB0000000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      g0 = gnt0;
      check("rr_gnt0", gnt0, (i % 2) == 0);
      check("rr_gnt1", gnt1, (i % 2) == 1);
      @(posedge clk); #1;
      if (g0) begin addr0 += 8; wdata0 += 1; end
      else    begin addr1 += 8; wdata1 += 1; end
    end
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    @(negedge clk);
    check("rr_mem20", mem[32'h20 >> 2], 32'hA0000000);
    check("rr_mem24", mem[32'h24 >> 2], 32'hB0000000);
    check("rr_mem28", mem[32'h28 >> 2], 32'hA0000001);
    check("rr_mem2c", mem[32'h2C >> 2], 32'hB0000001);

    // Locked port-1 burst against a waiting port 0.
    @(posedge clk); #1
    req0 = 1; we0 = 0; addr0 = 32'h10;
    req1 = 1; we1 = 0; addr1 = 32'h40; lock1 = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      g1 = gnt1;
      check("bu_gnt1", gnt1, (i < 8) || (i == 9));
      check("bu_gnt0", gnt0, i == 8);
      if (i == 8) check("bu_cnt_full", dut.burst_cnt_q, 8);
      if (i == 9) check("bu_cnt_clr", dut.burst_cnt_q, 0);
      @(posedge clk); #1;
      if (g1) addr1 += 4;
      else    addr0 += 4;
    end
    req0 = 0; req1 = 0; lock1 = 0;

    // Alternating reads: port 0 at 0x00, then port 1 at 0x04.
    req0 = 1; we0 = 0; addr0 = 32'h0;
    @(negedge clk);
    check("alt_gnt0", gnt0, 1);
    @(posedge clk); #1 req0 = 0; req1 = 1; we1 = 0; addr1 = 32'h4;
    @(negedge clk);
    check("alt_gnt1", gnt1, 1);
    check("alt_rvalid0", rvalid0, 1);
    check("alt_rdata0", rdata0, 32'h11111111);
    check("alt_rvalid1_lo", rvalid1, 0);
    @(posedge clk); #1 req1 = 0;
    @(negedge clk);
    check("alt_rvalid1", rvalid1, 1);
    check("alt_rdata1", rdata1, 32'h22222222);
    check("alt_rvalid0_lo", rvalid0, 0);

    // Reset in the cycle after a locked port-1 read grant.
    @(posedge clk); #1 req1 = 1; we1 = 0; addr1 = 32'h4; lock1 = 1;
    @(negedge clk);
    check("rst_gnt1", gnt1, 1);
    @(posedge clk); #1 req1 = 0; lock1 = 0; reset = 1;
    @(negedge clk);
    check("rst_rvalid1", rvalid1, 0);
    check("rst_rdata1", rdata1, 0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    check("rst_lw", dut.last_winner_q, 1);
    check("rst_cnt", dut.burst_cnt_q, 0);
    check("rst_rvalid1_after", rvalid1, 0);
    @(posedge clk); #1
    req0 = 1; we0 = 0; addr0 = 32'h10;
    req1 = 1; we1 = 0; addr1 = 32'h14;
    @(negedge clk);
    check("rst_tie_gnt0", gnt0, 1);
    check("rst_tie_gnt1", gnt1, 0);
    @(posedge clk); #1 req0 = 0; req1 = 0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
